// File: rtl/imem_access_ctrl_pkg.sv
// Shared types and constants for the instruction-memory access controller.
// Holds the FSM state encoding, the halt marker and the byte-packing sizes.
package imem_ctrl_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RUN       = 3'd3,
    ST_DUMP_RD   = 3'd4,
    ST_DUMP_WAIT = 3'd5
  } state_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int DEF_NB_DATA    = 32;
  localparam int DEF_NB_BYTE    = 8;
  localparam int BYTES_PER_WORD = DEF_NB_DATA / DEF_NB_BYTE;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int BCNT_W = cnt_width(BYTES_PER_WORD);

endpackage

// File: rtl/imem_access_ctrl_if.sv
// Command, UART byte, CPU fetch, memory and dump signals of the controller.
// slave: controller side; master: environment (debug unit, UART, memory).
interface imem_access_ctrl_if
  import imem_ctrl_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDRESS = 4,
  parameter int NB_BYTE    = 8
);

  logic                  i_load_start;
  logic [NB_BYTE-1:0]    i_rx_byte;
  logic                  i_rx_valid;
  logic                  i_run;
  logic                  i_stop;
  logic                  i_dump_start;
  logic [NB_ADDRESS-1:0] i_cpu_r_addr;
  logic                  i_cpu_r_en;
  logic [NB_DATA-1:0]    o_cpu_r_data;
  logic                  o_mem_w_en;
  logic [NB_ADDRESS-1:0] o_mem_w_addr;
  logic [NB_DATA-1:0]    o_mem_w_data;
  logic                  o_mem_r_en;
  logic [NB_ADDRESS-1:0] o_mem_r_addr;
  logic [NB_DATA-1:0]    i_mem_r_data;
  logic [NB_DATA-1:0]    o_dump_data;
  logic                  o_dump_valid;
  logic                  i_dump_ready;
  logic                  o_load_done;
  logic [ST_W-1:0]       o_state;

  modport slave (
    input  i_load_start, i_rx_byte, i_rx_valid,
    input  i_run, i_stop, i_dump_start,
    input  i_cpu_r_addr, i_cpu_r_en,
    input  i_mem_r_data, i_dump_ready,
    output o_cpu_r_data,
    output o_mem_w_en, o_mem_w_addr, o_mem_w_data,
    output o_mem_r_en, o_mem_r_addr,
    output o_dump_data, o_dump_valid,
    output o_load_done, o_state
  );

  modport master (
    output i_load_start, i_rx_byte, i_rx_valid,
    output i_run, i_stop, i_dump_start,
    output i_cpu_r_addr, i_cpu_r_en,
    output i_mem_r_data, i_dump_ready,
    input  o_cpu_r_data,
    input  o_mem_w_en, o_mem_w_addr, o_mem_w_data,
    input  o_mem_r_en, o_mem_r_addr,
    input  o_dump_data, o_dump_valid,
    input  o_load_done, o_state
  );

endinterface

// File: rtl/imem_access_ctrl_packer.sv
// Assembles bytes MSB-first into a word; pulses o_word_ready with the last byte.
// Ports: i_byte/i_valid in, i_clear restarts, o_word is the shift register.
module byte_word_packer
  import imem_ctrl_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_BYTE-1:0] i_byte,
  input  logic               i_valid,
  input  logic               i_clear,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_ready
);

  localparam int BPW = NB_DATA / NB_BYTE;
  localparam int CW  = cnt_width(BPW);
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [NB_DATA-1:0] word_q, word_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last;

  assign last = (cnt_q == LAST);

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (i_clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (i_valid) begin
      word_d = {word_q[NB_DATA-NB_BYTE-1:0], i_byte};
      cnt_d  = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_ready = i_valid && !i_clear && last;

endmodule

// File: rtl/imem_access_ctrl.sv
// Time-shares instruction memory between loader, CPU fetch and debug dump.
// Ports: i_clk, i_rst_n, bus (slave). Option: LOAD_HALT_DETECT_EN.
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDRESS = 4,
  parameter int NB_BYTE    = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  imem_access_ctrl_if.slave bus
);

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic [NB_ADDRESS-1:0] waddr_q, waddr_d;
  logic [NB_ADDRESS-1:0] raddr_q, raddr_d;
  logic [NB_DATA-1:0]    ddata_q, ddata_d;
  logic                  dvalid_q, dvalid_d;
  logic                  done_q, done_d;

  logic                  pk_valid;
  logic                  pk_clear;
  logic [NB_DATA-1:0]    pk_word;
  logic                  pk_ready;
  logic                  halt;

  logic                  w_en;
  logic [NB_ADDRESS-1:0] w_addr;
  logic [NB_DATA-1:0]    w_data;
  logic                  r_en;
  logic [NB_ADDRESS-1:0] r_addr;

  byte_word_packer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_packer (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .i_byte       (bus.i_rx_byte),
    .i_valid      (pk_valid),
    .i_clear      (pk_clear),
    .o_word       (pk_word),
    .o_word_ready (pk_ready)
  );

`ifdef LOAD_HALT_DETECT_EN
  localparam logic [NB_DATA-1:0] HALT =
    NB_DATA'(HALT_WORD);
  assign halt = (pk_word == HALT);
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    ddata_d  = ddata_q;
    dvalid_d = dvalid_q;
    done_d   = 1'b0;
    pk_valid = 1'b0;
    pk_clear = 1'b0;
    w_en     = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    r_en     = 1'b0;
    r_addr   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_load_start) begin
          state_d  = ST_LOAD;
          waddr_d  = '0;
          pk_clear = 1'b1;
        end else if (bus.i_dump_start) begin
          state_d = ST_DUMP_RD;
          raddr_d = '0;
        end else if (bus.i_run) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        pk_valid = bus.i_rx_valid;
        if (pk_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // The byte counter has already wrapped, so a byte
        // arriving now becomes byte 0 of the next word.
        pk_valid = bus.i_rx_valid;
        w_en     = 1'b1;
        w_addr   = waddr_q;
        w_data   = pk_word;
        if (waddr_q == LAST_ADDR || halt) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          waddr_d = waddr_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        r_en   = bus.i_cpu_r_en;
        r_addr = bus.i_cpu_r_addr;
        if (bus.i_stop) state_d = ST_IDLE;
      end
      ST_DUMP_RD: begin
        r_en    = 1'b1;
        r_addr  = raddr_q;
        state_d = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (!dvalid_q) begin
          ddata_d  = bus.i_mem_r_data;
          dvalid_d = 1'b1;
        end else if (bus.i_dump_ready) begin
          dvalid_d = 1'b0;
          if (raddr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end else begin
            raddr_d = raddr_q + 1'b1;
            state_d = ST_DUMP_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      waddr_q  <= '0;
      raddr_q  <= '0;
      ddata_q  <= '0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      ddata_q  <= ddata_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_cpu_r_data = bus.i_mem_r_data;
  assign bus.o_mem_w_en   = w_en;
  assign bus.o_mem_w_addr = w_addr;
  assign bus.o_mem_w_data = w_data;
  assign bus.o_mem_r_en   = r_en;
  assign bus.o_mem_r_addr = r_addr;
  assign bus.o_dump_data  = ddata_q;
  assign bus.o_dump_valid = dvalid_q;
  assign bus.o_load_done  = done_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl with a memory and dump consumer.
// Expected words come from a byte-stream model of the load.
module tb_imem_access_ctrl;
  import imem_ctrl_pkg::*;

  localparam int NB_DATA    = 32;
  localparam int NB_ADDRESS = 4;
  localparam int NB_BYTE    = 8;
  localparam int DEPTH      = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_access_ctrl_if #(
    .NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS), .NB_BYTE(NB_BYTE)
  ) bus ();

  imem_access_ctrl #(
    .NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS), .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    longint      c;
  } wr_t;

  typedef struct {
    logic       ld;
    logic       dmp;
    logic       run;
    logic [2:0] st;
    logic       ren;
  } arb_vec_t;

  logic [31:0] mem [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  wr_t         wr_q [$];
  logic [31:0] dump_q [$];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  int          done_cnt = 0;
  longint      done_cyc = 0;
  int          stab_err = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_data = '0;
  int          rdy_mode = 0;
  int          hold_cnt = 0;

  // memory model: 1-cycle synchronous read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_mem_w_en) mem[bus.o_mem_w_addr] <= bus.o_mem_w_data;
    if (bus.o_mem_r_en) bus.i_mem_r_data <= mem[bus.o_mem_r_addr];
  end

  // dump consumer
  always @(posedge clk) begin
    #1;
    if (bus.o_dump_valid) begin
      if (rdy_mode == 0) bus.i_dump_ready = ($urandom_range(0, 1) == 1);
      else               bus.i_dump_ready = (hold_cnt >= 5);
      hold_cnt++;
    end else begin
      bus.i_dump_ready = 1'b0;
      hold_cnt = 0;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (bus.o_mem_w_en)
      wr_q.push_back('{bus.o_mem_w_addr, bus.o_mem_w_data, cyc});
    if (bus.o_load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.o_dump_valid && bus.i_dump_ready)
      dump_q.push_back(bus.o_dump_data);
    if (rst_n && prev_hold &&
        (!bus.o_dump_valid || bus.o_dump_data !== prev_data))
      stab_err++;
    prev_hold = rst_n && bus.o_dump_valid && !bus.i_dump_ready;
    prev_data = bus.o_dump_data;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bytes(input logic [7:0] b [$], input int maxgap);
    foreach (b[i]) begin
      bus.i_rx_byte  = b[i];
      bus.i_rx_valid = 1'b1;
      tick();
      bus.i_rx_valid = 1'b0;
      tick($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_load(input logic [7:0] b [$], input int maxgap);
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
    send_bytes(b, maxgap);
    tick(3);
  endtask

  // Model: words are consecutive byte quadruples, first byte most significant.
  task automatic check_load(input string tag, input logic [7:0] b [$],
                            input int wbase, input int dbase);
    logic [31:0] w [DEPTH];
    int n;
    n = DEPTH;
    for (int i = 0; i < DEPTH; i++)
      w[i] = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
`ifdef LOAD_HALT_DETECT_EN
    for (int i = DEPTH - 1; i >= 0; i--)
      if (w[i] == 32'hFFFF_FFFF) n = i + 1;
`endif
    chk({tag, " wr_count"}, 64'(wr_q.size() - wbase), 64'(n));
    for (int i = 0; i < n && wbase + i < wr_q.size(); i++) begin
      chk($sformatf("%s wr%0d addr", tag, i), 64'(wr_q[wbase+i].a), 64'(i));
      chk($sformatf("%s wr%0d data", tag, i), 64'(wr_q[wbase+i].d), 64'(w[i]));
      exp_mem[i] = w[i];
    end
    chk({tag, " done_count"}, 64'(done_cnt - dbase), 64'd1);
    if (wr_q.size() > 0)
      chk({tag, " done_timing"}, 64'(done_cyc),
          64'(wr_q[wr_q.size()-1].c + 1));
    chk({tag, " idle_after"}, 64'(bus.o_state), 64'd0);
  endtask

  task automatic do_dump(input int mode, input string tag);
    int base, sbase, k;
    rdy_mode = mode;
    base  = dump_q.size();
    sbase = stab_err;
    bus.i_dump_start = 1'b1;
    tick();
    bus.i_dump_start = 1'b0;
    k = 0;
    while ((dump_q.size() - base < DEPTH || bus.o_state != 3'd0) && k < 2000) begin
      tick();
      k++;
    end
    chk({tag, " timeout"}, 64'(k < 2000), 64'd1);
    chk({tag, " count"}, 64'(dump_q.size() - base), 64'(DEPTH));
    for (int i = 0; i < DEPTH && base + i < dump_q.size(); i++)
      chk($sformatf("%s word%0d", tag, i), 64'(dump_q[base+i]), 64'(exp_mem[i]));
    chk({tag, " stable"}, 64'(stab_err - sbase), 64'd0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    arb_vec_t    vecs [7];
    logic [7:0]  bytes [$];
    int          wb, db;

    vecs[0] = '{1, 0, 0, 3'd1, 0};
    vecs[1] = '{1, 1, 0, 3'd1, 0};
    vecs[2] = '{1, 1, 1, 3'd1, 0};
    vecs[3] = '{0, 1, 1, 3'd4, 1};
    vecs[4] = '{0, 1, 0, 3'd4, 1};
    vecs[5] = '{0, 0, 1, 3'd3, 0};
    vecs[6] = '{0, 0, 0, 3'd0, 0};

    bus.i_load_start = 0; bus.i_rx_byte = 0; bus.i_rx_valid = 0;
    bus.i_run = 0; bus.i_stop = 0; bus.i_dump_start = 0;
    bus.i_cpu_r_addr = 0; bus.i_cpu_r_en = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

    // reset state
    tick(3);
    chk("rst state", 64'(bus.o_state), 64'd0);
    chk("rst w_en", 64'(bus.o_mem_w_en), 64'd0);
    chk("rst w_addr", 64'(bus.o_mem_w_addr), 64'd0);
    chk("rst w_data", 64'(bus.o_mem_w_data), 64'd0);
    chk("rst r_en", 64'(bus.o_mem_r_en), 64'd0);
    chk("rst r_addr", 64'(bus.o_mem_r_addr), 64'd0);
    chk("rst dump", 64'({bus.o_dump_valid, bus.o_dump_data}), 64'd0);
    chk("rst done", 64'(bus.o_load_done), 64'd0);
    rst_n = 1'b1;
    tick();

    // arbitration table
    for (int i = 0; i < 7; i++) begin
      bus.i_load_start = vecs[i].ld;
      bus.i_dump_start = vecs[i].dmp;
      bus.i_run        = vecs[i].run;
      tick();
      bus.i_load_start = 0; bus.i_dump_start = 0; bus.i_run = 0;
      #1;
      chk($sformatf("arb%0d state", i), 64'(bus.o_state), 64'(vecs[i].st));
      chk($sformatf("arb%0d r_en", i), 64'(bus.o_mem_r_en), 64'(vecs[i].ren));
      async_reset();
    end

    // ignored bytes in IDLE and RUN
    wb = wr_q.size();
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_bytes(bytes, 0);
    bus.i_run = 1; tick(); bus.i_run = 0;
    send_bytes(bytes, 0);
    chk("ignored run_state", 64'(bus.o_state), 64'd3);
    chk("ignored writes", 64'(wr_q.size() - wb), 64'd0);
    bus.i_stop = 1; tick(); bus.i_stop = 0;
    chk("ignored stop", 64'(bus.o_state), 64'd0);

    // reset mid-load after two bytes
    bus.i_load_start = 1; tick(); bus.i_load_start = 0;
    bytes = '{8'h55, 8'h66};
    send_bytes(bytes, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst state", 64'(bus.o_state), 64'd0);
    chk("midrst w_en", 64'(bus.o_mem_w_en), 64'd0);
    rst_n = 1'b1;
    tick();

    // full load 0x00..0x3F, back-to-back bytes
    bytes.delete();
    for (int i = 0; i < 64; i++) bytes.push_back(8'(i));
    wb = wr_q.size(); db = done_cnt;
    do_load(bytes, 0);
    check_load("full", bytes, wb, db);
    if (wr_q.size() >= wb + 16) begin
      chk("full addr0", 64'(wr_q[wb].d), 64'h0001_0203);
      chk("full addr15", 64'(wr_q[wb+15].d), 64'h3C3D_3E3F);
    end else begin
      chk("full writes present", 64'(wr_q.size() - wb), 64'd16);
    end

    // CPU run pass-through
    bus.i_run = 1; tick(); bus.i_run = 0;
    chk("run state", 64'(bus.o_state), 64'd3);
    bus.i_cpu_r_addr = 4'd7; bus.i_cpu_r_en = 1;
    #1;
    chk("run r_addr", 64'(bus.o_mem_r_addr), 64'd7);
    chk("run r_en", 64'(bus.o_mem_r_en), 64'd1);
    bus.i_load_start = 1;
    tick();
    bus.i_load_start = 0;
    chk("run cpu_data", 64'(bus.o_cpu_r_data), 64'h1C1D_1E1F);
    chk("run ignore_load", 64'(bus.o_state), 64'd3);
    bus.i_cpu_r_en = 0;
    bus.i_stop = 1; tick(); bus.i_stop = 0;
    chk("stop state", 64'(bus.o_state), 64'd0);
    chk("stop r_en", 64'(bus.o_mem_r_en), 64'd0);

    // dump with 5 cycles of backpressure per word
    do_dump(1, "dump_bp");

    // halt word
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wb = wr_q.size(); db = done_cnt;
    do_load(bytes, 0);
    chk("halt wr_count", 64'(wr_q.size() - wb), 64'd2);
    if (wr_q.size() >= wb + 2) begin
      chk("halt w0", 64'({wr_q[wb].a, wr_q[wb].d}), 64'({4'd0, 32'h1234_5678}));
      chk("halt w1", 64'({wr_q[wb+1].a, wr_q[wb+1].d}), 64'({4'd1, 32'hFFFF_FFFF}));
    end
    exp_mem[0] = 32'h1234_5678;
    exp_mem[1] = 32'hFFFF_FFFF;
`ifdef LOAD_HALT_DETECT_EN
    chk("halt done", 64'(done_cnt - db), 64'd1);
    chk("halt state", 64'(bus.o_state), 64'd0);
`else
    chk("halt done", 64'(done_cnt - db), 64'd0);
    chk("halt state", 64'(bus.o_state), 64'd1);
    async_reset();
`endif

    // randomized loads and dumps
    for (int r = 0; r < 3; r++) begin
      bytes.delete();
      for (int i = 0; i < 64; i++) bytes.push_back(8'($urandom_range(0, 255)));
      wb = wr_q.size(); db = done_cnt;
      do_load(bytes, 2);
      check_load($sformatf("rnd%0d", r), bytes, wb, db);
      do_dump(0, $sformatf("rdump%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Owns both ports of the 32-bit instruction memory (rom_memory32) and time-shares them between three users.
- Users:
  - Program loader: a UART byte stream assembled into words and written sequentially.
  - CPU fetch: pass-through of the read port while running.
  - Debug dump: sequential readback of every word over a valid/ready handshake.
- Sits between the debug unit / UART RX and the memory, in front of the pipeline's fetch stage.

Parameters:
- NB_DATA, 32, memory word width; must be a multiple of NB_BYTE.
- NB_ADDRESS, 4, memory address width; depth = 2^NB_ADDRESS words.
- NB_BYTE, 8, width of an RX byte.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load_start  in  1  pulse: begin program load (honoured in IDLE only).
- i_rx_byte  in  NB_BYTE  received byte.
- i_rx_valid  in  1  i_rx_byte valid this cycle; single-cycle per byte.
- i_run  in  1  pulse: hand read port to CPU (IDLE only).
- i_stop  in  1  pulse: leave RUN.
- i_dump_start  in  1  pulse: begin memory dump (IDLE only).
- i_cpu_r_addr  in  NB_ADDRESS  CPU fetch address.
- i_cpu_r_en  in  1  CPU fetch enable.
- o_cpu_r_data  out  NB_DATA  CPU fetch data (= i_mem_r_data).
- o_mem_w_en  out  1  memory write enable.
- o_mem_w_addr  out  NB_ADDRESS  memory write address.
- o_mem_w_data  out  NB_DATA  memory write data.
- o_mem_r_en  out  1  memory read enable.
- o_mem_r_addr  out  NB_ADDRESS  memory read address.
- i_mem_r_data  in  NB_DATA  memory read data; 1-cycle synchronous latency.
- o_dump_data  out  NB_DATA  dumped word.
- o_dump_valid  out  1  o_dump_data valid.
- i_dump_ready  in  1  consumer accepts dumped word.
- o_load_done  out  1  one-cycle pulse at end of load.
- o_state  out  3  current FSM state, for the debug unit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - All outputs reset to 0; state = IDLE; address counters and byte counter = 0.
  - Reset mid-LOAD or mid-DUMP aborts immediately; a partial word is discarded.
- States (pkg encoding): IDLE=0, LOAD=1, WRITE=2, RUN=3, DUMP_RD=4, DUMP_WAIT=5.
- IDLE:
  - Priority when pulses coincide: i_load_start > i_dump_start > i_run.
  - Entering LOAD clears the write address and byte counter.
  - Entering DUMP_RD clears the read address.
- LOAD:
  - Each i_rx_valid shifts i_rx_byte into the word, MSB first (first byte -> bits [31:24]).
  - On the 4th byte go to WRITE. Bytes arriving outside LOAD are ignored.
- WRITE:
  - Exactly one cycle: o_mem_w_en=1, o_mem_w_addr=word counter, o_mem_w_data=assembled word.
  - If the word counter = 2^NB_ADDRESS-1 (or the halt condition holds, see Optional Feature): pulse o_load_done, go to IDLE.
  - Otherwise increment the counter, reset the byte counter, return to LOAD.
  - No wrap-around: the load never writes past the last address.
  - An i_rx_valid arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
- RUN:
  - o_mem_r_en = i_cpu_r_en and o_mem_r_addr = i_cpu_r_addr, combinationally.
  - i_stop returns to IDLE; all other pulses are ignored.
- Read port outside RUN and DUMP_RD: o_mem_r_en=0, o_mem_r_addr=0. o_mem_w_en=0 outside WRITE.
- DUMP_RD:
  - Drive o_mem_r_en=1 with o_mem_r_addr=dump counter for one cycle, then go to DUMP_WAIT.
- DUMP_WAIT:
  - First cycle: register i_mem_r_data into o_dump_data and set o_dump_valid.
  - Hold data and valid stable until i_dump_ready. A ready seen in the same cycle valid rises completes the transfer on the next edge.
  - On transfer, clear valid. If the counter = 2^NB_ADDRESS-1, go to IDLE; else increment and go to DUMP_RD.
  - Throughput: at most one word per 3 cycles.

Optional Feature:
- Macro: LOAD_HALT_DETECT_EN.
- Defined: a written word equal to HALT_WORD (32'hFFFF_FFFF) is still written, then the load terminates with o_load_done, exactly as at the last address.
- Undefined: the load always writes all 2^NB_ADDRESS words; HALT_WORD is ordinary data.

Decomposition:
- Package imem_ctrl_pkg:
  - state enum/localparams;
  - HALT_WORD;
  - BYTES_PER_WORD = NB_DATA/NB_BYTE;
  - byte-counter width.
- One sub-module, byte_word_packer: shift register plus byte counter.
  - Inputs: byte, valid, clear.
  - Outputs: word, word_ready pulse.
- The FSM and address counters stay in imem_access_ctrl.

Test Plan:
- Reset:
  - Stimulus: hold i_rst_n=0, then assert it asynchronously mid-LOAD after 2 bytes.
  - Response: all outputs 0, o_state=0; a following full load starts at address 0.
- Full load:
  - Stimulus: i_load_start, then 64 bytes 0x00..0x3F.
  - Response: 16 writes; addr 0 data 0x00010203, addr 15 data 0x3C3D3E3F; o_load_done pulses once, after the addr-15 write.
- Halt (macro defined):
  - Stimulus: 8 bytes 0x12345678, FFFFFFFF.
  - Response: writes at addr 0 and 1 only; then o_load_done, IDLE.
  - Macro undefined: the load keeps waiting in LOAD.
- Dump with backpressure:
  - Stimulus: after the full load, i_dump_start with i_dump_ready low for 5 cycles per word.
  - Response: 16 words in address order, each held stable while valid and unready; returns to IDLE.
- Arbitration:
  - Stimulus: i_load_start and i_dump_start in the same cycle.
  - Response: LOAD entered.
  - Stimulus: i_run then i_cpu_r_addr=7 with i_cpu_r_en=1.
  - Response: o_mem_r_addr=7 that cycle; o_cpu_r_data=0x1C1D1E1F next cycle; i_stop returns to IDLE.
- Ignored inputs:
  - Stimulus: i_rx_valid pulses in IDLE and RUN.
  - Response: no o_mem_w_en assertion.
